gray_step_sched: RTL and testbench

- Scheduler that shares one 5-bit Gray-code counter between two requesters.
- Each requester asks for N Gray steps. The block arbitrates round-robin, then advances the owned counter by one Gray code every STEP_DIV clocks. It pulses done to the owner after the last step.
- Sits between the control logic and the Gray counter datapath. The counter is held internally as binary and presented as registered Gray.

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_core.sv | 38 +++
 rtl/gray_step_sched.sv | 130 +++++++++++++
 tb/tb_gray_step_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step scheduler: FSM encoding, counter width
// and the binary-to-Gray conversion used by the counter datapath.
package gray_pkg;

  localparam int GRAY_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_core.sv
// Binary counter with a registered Gray-coded view; clr wins over inc.
// WIDTH is expected to equal GRAY_W so the package conversion applies directly.
module gray_core
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nx;

  always_comb begin
    bin_nx = bin;
    if (clr) begin
      bin_nx = '0;
    end else if (inc) begin
      bin_nx = bin + WIDTH'(1);
    end
  end

  // Gray is derived from the next binary value so both registers move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin      <= '0;
      gray_out <= '0;
    end else begin
      bin      <= bin_nx;
      gray_out <= bin2gray(bin_nx);
    end
  end

endmodule

// File: rtl/gray_step_sched.sv
// Round-robin scheduler sharing one Gray counter between two requesters; the
// owner gets N steps, one every STEP_DIV clocks, then a one-cycle done pulse.
module gray_step_sched
  import gray_pkg::*;
#(
  parameter int WIDTH    = GRAY_W,
  parameter int CNT_W    = 5,
  parameter int STEP_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] steps0,
  input  logic [CNT_W-1:0] steps1,
  input  logic             clr,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [WIDTH-1:0] gray_out,
  output logic             step,
  output logic [1:0]       done,
  output logic [1:0]       dbg_state
);

  localparam int PH_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STEP_DIV - 1);

  // Handshake: req[i] stays high until done[i] pulses (or it is withdrawn to
  // abort); grant[i] is held from the cycle after arbitration through done.

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       grant_d;
  logic             step_due;
  logic             pick;
  logic [CNT_W-1:0] pick_steps;

  assign step_due = (state_q == ST_RUN) && (phase_q == PH_LAST);

  // With both requesting, the one not served last wins; last_q resets to 1
  // so requester 0 goes first.
  always_comb begin
    if (req[0] && req[1]) begin
      pick = ~last_q;
    end else begin
      pick = req[1];
    end
    pick_steps = pick ? steps1 : steps0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    grant_d = grant;
    case (state_q)
      ST_IDLE: begin
        if (!clr && (req != 2'b00)) begin
          owner_d = pick;
          last_d  = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          phase_d = '0;
          rem_d   = pick_steps;
          state_d = (pick_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (step_due) begin
          phase_d = '0;
          rem_d   = rem_q - CNT_W'(1);
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
        // A withdrawn request aborts silently; a step due this cycle still lands.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else if (step_due && (rem_q == CNT_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      phase_q <= '0;
      rem_q   <= '0;
      grant   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      grant   <= grant_d;
    end
  end

  assign step      = step_due;
  assign done      = (state_q == ST_DONE) ? grant : 2'b00;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  gray_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr && (state_q == ST_IDLE)),
    .inc     (step_due),
    .gray_out(gray_out)
  );

endmodule

// File: tb/tb_gray_step_sched.sv
// Bench for gray_step_sched: vector table, hand-written abort/clr/reset
// sequences and randomized transactions checked against a transaction model.
module tb_gray_step_sched;

  localparam int W  = 5;
  localparam int CW = 5;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [CW-1:0] steps0 = '0;
  logic [CW-1:0] steps1 = '0;
  logic          clr = 1'b0;
  logic [1:0]    grant;
  logic          busy;
  logic [W-1:0]  gray_out;
  logic          step;
  logic [1:0]    done;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: counter value and who was served last (1 => requester 0 next).
  int       model_bin;
  bit       model_last;
  logic [W-1:0] exp_q[$];

  typedef struct {
    bit            pre_reset;
    logic [1:0]    r;
    logic [CW-1:0] s0;
    logic [CW-1:0] s1;
    bit            hold;
    logic [1:0]    exp_grant;
    logic [W-1:0]  exp_gray;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  gray_step_sched #(.WIDTH(W), .CNT_W(CW), .STEP_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .steps0   (steps0),
    .steps1   (steps1),
    .clr      (clr),
    .grant    (grant),
    .busy     (busy),
    .gray_out (gray_out),
    .step     (step),
    .done     (done),
    .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] gray_of(input int b);
    int m;
    m = b % 32;
    return W'(m ^ (m >> 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_gray"}, 32'(gray_out), 0);
    check({tag, "_step"}, 32'(step), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic reset_dut;
    req = 2'b00; clr = 1'b0; steps0 = '0; steps1 = '0;
    rst_n = 1'b0;
    step_clk;
    check_reset_vals("reset");
    step_clk;
    rst_n = 1'b1;
    model_bin = 0;
    model_last = 1'b1;
  endtask

  // One full grant..done transaction; must be entered in IDLE at a sample point.
  task automatic txn(input logic [1:0] r, input logic [CW-1:0] s0, input logic [CW-1:0] s1,
                     input bit hold, output logic [1:0] got_grant);
    int owner, n, lat, c;
    logic [1:0]   oh;
    logic [W-1:0] cur, prev_obs;
    owner = (r == 2'b11) ? (model_last ? 0 : 1) : (r[1] ? 1 : 0);
    n     = owner ? int'(s1) : int'(s0);
    oh    = owner ? 2'b10 : 2'b01;
    req = r; steps0 = s0; steps1 = s1;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      step_clk;
      lat++;
      if (grant != 2'b00) break;
    end
    got_grant = grant;
    check("grant_latency", lat, 1);
    if (grant == 2'b00) begin
      req = 2'b00;
      return;
    end
    check("grant_owner", 32'(grant), 32'(oh));
    exp_q.delete();
    for (int k = 1; k <= n; k++) exp_q.push_back(gray_of(model_bin + k));
    cur = gray_of(model_bin);
    prev_obs = gray_out;
    for (c = 0; c <= n * SD + 1; c++) begin
      if (c > 0) step_clk;
      if (c <= n * SD) begin
        check("grant_held", 32'(grant), 32'(oh));
        check("busy_high", 32'(busy), 1);
      end else begin
        check("grant_released", 32'(grant), 0);
        check("busy_low", 32'(busy), 0);
      end
      check("step", 32'(step), 32'((c < n * SD) && (c % SD == SD - 1)));
      check("done", 32'(done), (c == n * SD) ? 32'(oh) : 0);
      if (c > 0 && c % SD == 0 && c <= n * SD && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("one_bit_flip", $countones(gray_out ^ prev_obs), 1);
      end
      check("gray_out", 32'(gray_out), 32'(cur));
      prev_obs = gray_out;
      if (c == n * SD && !hold) req = 2'b00;
    end
    check("exp_q_drained", exp_q.size(), 0);
    model_bin  = (model_bin + n) % 32;
    model_last = (owner != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    vecs[0] = '{1'b0, 2'b01, 5'd3,  5'd0, 1'b0, 2'b01, 5'b00010};
    vecs[1] = '{1'b1, 2'b11, 5'd1,  5'd1, 1'b1, 2'b01, 5'b00001};
    vecs[2] = '{1'b0, 2'b11, 5'd1,  5'd1, 1'b1, 2'b10, 5'b00011};
    vecs[3] = '{1'b0, 2'b11, 5'd1,  5'd1, 1'b0, 2'b01, 5'b00010};
    vecs[4] = '{1'b0, 2'b10, 5'd0,  5'd0, 1'b0, 2'b10, 5'b00010};
    vecs[5] = '{1'b1, 2'b01, 5'd30, 5'd0, 1'b0, 2'b01, 5'b10001};
    vecs[6] = '{1'b0, 2'b10, 5'd0,  5'd3, 1'b0, 2'b10, 5'b00001};

    #1;
    check_reset_vals("por");
    reset_dut;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_reset) reset_dut;
      txn(vecs[v].r, vecs[v].s0, vecs[v].s1, vecs[v].hold, g);
      check($sformatf("vec%0d_grant", v), 32'(g), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d_final_gray", v), 32'(gray_out), 32'(vecs[v].exp_gray));
    end

    // Abort after the first of four steps, then clr in IDLE vs a request.
    reset_dut;
    req = 2'b01; steps0 = 5'd4;
    step_clk;
    check("abort_grant", 32'(grant), 32'(2'b01));
    step_clk;
    step_clk;
    check("abort_first_step", 32'(gray_out), 32'(5'b00001));
    req = 2'b00;
    step_clk;
    check("abort_grant_drop", 32'(grant), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_done", 32'(done), 0);
    check("abort_hold_gray", 32'(gray_out), 32'(5'b00001));
    step_clk;
    check("abort_no_done_late", 32'(done), 0);
    check("abort_gray_still", 32'(gray_out), 32'(5'b00001));
    clr = 1'b1; req = 2'b01; steps0 = 5'd2;
    step_clk;
    check("clr_zeroes", 32'(gray_out), 0);
    check("clr_beats_req", 32'(grant), 0);
    clr = 1'b0;
    step_clk;
    check("req_after_clr", 32'(grant), 32'(2'b01));
    clr = 1'b1;
    step_clk;
    check("clr_run_ignored_c1", 32'(gray_out), 0);
    check("clr_run_step_due", 32'(step), 1);
    step_clk;
    clr = 1'b0;
    check("clr_run_step_lands", 32'(gray_out), 32'(5'b00001));
    step_clk;
    step_clk;
    check("clr_run_done", 32'(done), 32'(2'b01));
    check("clr_run_final", 32'(gray_out), 32'(5'b00011));
    req = 2'b00;
    step_clk;
    check("clr_run_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a run.
    req = 2'b01; steps0 = 5'd5;
    step_clk;
    step_clk;
    step_clk;
    step_clk;
    check("mid_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    req = 2'b00;
    step_clk;
    rst_n = 1'b1;
    model_bin = 0;
    model_last = 1'b1;
    txn(2'b01, 5'd2, 5'd0, 1'b0, g);
    check("post_rst_final", 32'(gray_out), 32'(5'b00011));

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      txn(2'($urandom_range(1, 3)), CW'($urandom_range(0, 6)), CW'($urandom_range(0, 6)),
          1'($urandom_range(0, 1)), g);
    end
    req = 2'b00;
    step_clk;
    step_clk;
    check("end_idle", 32'(dbg_state), 0);
    check("end_gray_model", 32'(gray_out), 32'(gray_of(model_bin)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
